tt_um_or_and_selector: RTL and testbench
========================================

TT_UM_OR_AND_SELECTOR -- requirements
Module: tt_um_or_and_selector

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port names SHALL be clk and rst_n; rst_n keeps the harness-standard name but is active-high (1 = reset).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous reset, asserted at logic 1, sampled on rising clk.
REQ-005 ena  input  1  design enable; 1 = update output register, 0 = hold.
REQ-006 ui_in  input  8  operand A; bit 7 also selects the operation.
REQ-007 uio_in  input  8  operand B.
REQ-008 uo_out  output  8  registered result.
REQ-009 uio_out  output  8  unused; constant 8'h00.
REQ-010 uio_oe  output  8  constant 8'h00 (all bidirectional pins are inputs).
REQ-011 Parameter SEL_BIT, default 7, gives the ui_in bit that selects the operation.

Function
REQ-012 Operation select: ui_in[SEL_BIT]=0 -> bitwise AND; ui_in[SEL_BIT]=1 -> bitwise OR.
REQ-013 The next result SHALL be (ui_in & uio_in) for AND, or (ui_in | uio_in) for OR, over all 8 bits.
REQ-014 The select bit SHALL take part in the operation as an ordinary operand bit.
REQ-015 The result SHALL be 8 bits with no carry, overflow or sign handling.
REQ-016 uo_out SHALL be registered: inputs sampled at rising edge N appear on uo_out after edge N.
REQ-017 Latency SHALL be 1 cycle, with no handshake.
REQ-018 When ena=0 and reset is deasserted, uo_out SHALL hold its value.
REQ-019 Input changes between edges SHALL NOT affect uo_out until the next enabled edge.
REQ-020 uio_out and uio_oe SHALL be constant 0 regardless of reset, ena or inputs.
REQ-021 If the select bit and operands change together, the value sampled at the edge SHALL decide both the operation and the result.

Reset
REQ-022 While rst_n=1 at a rising edge, uo_out SHALL become 8'h00, regardless of ena and inputs.
REQ-023 Reset SHALL take priority over ena.
REQ-024 Reset asserted mid-operation SHALL clear uo_out on that edge, with no other retained state.
REQ-025 On the first enabled edge after reset deasserts, uo_out SHALL show the function of the inputs sampled at that edge.
REQ-026 The block SHALL have no asynchronous reset path.

Structure
REQ-027 A shared package SHALL hold:
- OP_AND = 1'b0 and OP_OR = 1'b1 (select encodings);
- the default select-bit index 7;
- DATA_W = 8.
REQ-028 A single purely combinational sub-module, or_and_unit, SHALL compute the AND/OR result from A, B and select.
REQ-029 The top level SHALL contain only:
- the or_and_unit instance;
- the result register with reset and enable;
- the constant uio assignments.
REQ-030 Unused inputs SHALL be consumed explicitly to avoid lint warnings.

Verification
REQ-031 ui_in=8'h14, uio_in=8'h1E, ena=1, one edge -> uo_out=8'h14 (AND).
REQ-032 ui_in=8'h94, uio_in=8'h1E, one edge -> uo_out=8'h9E (OR).
REQ-033 ui_in=8'h00, uio_in=8'h00 -> uo_out=8'h00.
REQ-034 ui_in=8'hFF, uio_in=8'hAA -> uo_out=8'hFF; then ui_in=8'h7F, uio_in=8'hAA -> uo_out=8'h2A.
REQ-035 Load a value, drop ena, change inputs for 3 edges -> uo_out unchanged; raise rst_n=1 for one edge -> uo_out=8'h00.
REQ-036 In every scenario, uio_out=8'h00 and uio_oe=8'h00 at all times.

Source files
------------

// File: rtl/tt_um_or_and_selector_pkg.sv
// -----------------------------------------------------------------------------
// tt_um_or_and_selector_pkg
//
// Purpose:
//   Shared definitions for the OR/AND selector block: datapath width, the
//   default index of the operation-select bit, and the operation encoding.
//
// Contents:
//   DATA_W          - operand / result width (8)
//   DEF_SEL_BIT     - default ui_in bit that chooses the operation (7)
//   op_e            - OP_AND = 1'b0, OP_OR = 1'b1
//   data_t          - DATA_W-wide operand / result vector
//   apply_op()      - reference bitwise function shared by the datapath
// -----------------------------------------------------------------------------
package tt_um_or_and_selector_pkg;

    localparam int DATA_W      = 8;
    localparam int DEF_SEL_BIT = 7;

    // The select bit maps directly onto this encoding, so a plain cast of the
    // sampled bit yields the operation.
    typedef enum logic {
        OP_AND = 1'b0,
        OP_OR  = 1'b1
    } op_e;

    typedef logic [DATA_W-1:0] data_t;

    // Pure bitwise combine. No carry or sign handling: every result bit
    // depends only on the two operand bits at the same position.
    function automatic data_t apply_op(input data_t a, input data_t b, input op_e op);
        data_t y;
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = '0;
        endcase
        return y;
    endfunction

endpackage : tt_um_or_and_selector_pkg

// File: rtl/tt_um_or_and_selector_or_and_unit.sv
// -----------------------------------------------------------------------------
// or_and_unit
//
// Purpose:
//   Purely combinational AND/OR datapath. Produces a & b or a | b across the
//   full width depending on the requested operation. Holds no state.
//
// Ports:
//   a   in  DATA_W  operand A
//   b   in  DATA_W  operand B
//   op  in  op_e    OP_AND or OP_OR
//   y   out DATA_W  combined result
// -----------------------------------------------------------------------------
module or_and_unit
    import tt_um_or_and_selector_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  op_e               op,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path before any branching; an unassigned path infers a latch.
        y = '0;
        y = apply_op(a, b, op);
    end

endmodule : or_and_unit

// File: rtl/tt_um_or_and_selector.sv
// -----------------------------------------------------------------------------
// tt_um_or_and_selector
//
// Purpose:
//   Registered bitwise AND/OR of two 8-bit operands. One bit of ui_in
//   (SEL_BIT, default 7) chooses the operation and also takes part in the
//   operation as an ordinary operand bit. One cycle of latency, no handshake.
//
// Parameters:
//   SEL_BIT  ui_in bit index selecting the operation (0 = AND, 1 = OR)
//
// Ports:
//   clk      in   1  rising-edge clock for all state
//   rst_n    in   1  synchronous reset, ACTIVE HIGH despite the name
//                    (1 = clear uo_out on the next rising edge)
//   ena      in   1  1 = load the new result, 0 = hold uo_out
//   ui_in    in   8  operand A (also carries the select bit)
//   uio_in   in   8  operand B
//   uo_out   out  8  registered result
//   uio_out  out  8  unused, tied to 8'h00
//   uio_oe   out  8  tied to 8'h00, all bidirectional pins are inputs
// -----------------------------------------------------------------------------
module tt_um_or_and_selector
    import tt_um_or_and_selector_pkg::*;
#(
    parameter int SEL_BIT = DEF_SEL_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] ui_in,
    input  logic [DATA_W-1:0] uio_in,
    output logic [DATA_W-1:0] uo_out,
    output logic [DATA_W-1:0] uio_out,
    output logic [DATA_W-1:0] uio_oe
);

    op_e               op;
    logic [DATA_W-1:0] result;

    // The select bit is read straight from the operand; the same edge that
    // samples the operands therefore also decides the operation.
    assign op = op_e'(ui_in[SEL_BIT]);

    or_and_unit u_or_and_unit (
        .a  (ui_in),
        .b  (uio_in),
        .op (op),
        .y  (result)
    );

    // Reset is synchronous and active high; it wins over ena.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_n) begin
            uo_out <= '0;
        end else if (ena) begin
            uo_out <= result;
        end
    end

    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule : tt_um_or_and_selector

// File: tb/tb_tt_um_or_and_selector.sv
// -----------------------------------------------------------------------------
// tb_tt_um_or_and_selector
//
// Self-checking bench for tt_um_or_and_selector. A behavioural model tracks
// the expected output register from the block's rules (reset clears, enabled
// edges load AND/OR of the sampled operands, otherwise hold).
// -----------------------------------------------------------------------------
module tb_tt_um_or_and_selector;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q = 8'h00;
    bit mon_on = 1'b0;

    tt_um_or_and_selector #(.SEL_BIT(7)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required < 1ms)", $time);
        $fatal(1);
    end

    // Reference: bit 7 of A selects OR when set, AND when clear.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++)
            r[i] = a[7] ? (a[i] | b[i]) : (a[i] & b[i]);
        return r;
    endfunction

    // Bidirectional pin outputs must read zero at all times.
    always @(negedge clk) begin
        if (mon_on) begin
            n_cmp++;
            if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
                n_fail++;
                $display("FAIL uio_const: uio_out=%h uio_oe=%h required 00/00 at %0t",
                         uio_out, uio_oe, $time);
            end
        end
    end

    // Apply inputs away from the edge, clock once, and update the model.
    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic en, input logic rst);
        @(negedge clk);
        ui_in  = a;
        uio_in = b;
        ena    = en;
        rst_n  = rst;
        if (rst)     exp_q = 8'h00;
        else if (en) exp_q = model(a, b);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive($urandom, $urandom, 1'b1, 1'b1);
        drive($urandom, $urandom, 1'b1, 1'b1);
        n_cmp++;
        if (uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: uo_out=%h required 00", uo_out);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [5] = '{8'h14, 8'h94, 8'h00, 8'hFF, 8'h7F};
        logic [7:0] vb [5] = '{8'h1E, 8'h1E, 8'h00, 8'hAA, 8'hAA};
        logic [7:0] vr [5] = '{8'h14, 8'h9E, 8'h00, 8'hFF, 8'h2A};
        for (int i = 0; i < 5; i++) begin
            drive(va[i], vb[i], 1'b1, 1'b0);
            n_cmp++;
            if (uo_out !== vr[i]) begin
                n_fail++;
                $display("FAIL vector%0d: a=%h b=%h uo_out=%h required %h",
                         i, va[i], vb[i], uo_out, vr[i]);
            end
        end
    endtask

    task automatic test_hold_then_reset();
        drive(8'h14, 8'h1E, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, 1'b0, 1'b0);
            n_cmp++;
            if (uo_out !== 8'h14) begin
                n_fail++;
                $display("FAIL hold%0d: uo_out=%h required 14", i, uo_out);
            end
        end
        drive($urandom, $urandom, 1'b0, 1'b1);
        n_cmp++;
        if (uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_over_hold: uo_out=%h required 00", uo_out);
        end
    endtask

    task automatic test_reset_priority();
        drive(8'hF0, 8'h0F, 1'b1, 1'b0);
        drive(8'hFF, 8'hFF, 1'b1, 1'b1);
        n_cmp++;
        if (uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_priority: uo_out=%h required 00", uo_out);
        end
        drive(8'h83, 8'h44, 1'b1, 1'b0);
        n_cmp++;
        if (uo_out !== 8'hC7) begin
            n_fail++;
            $display("FAIL first_after_reset: uo_out=%h required c7", uo_out);
        end
    endtask

    task automatic test_between_edges();
        drive(8'h3C, 8'h0F, 1'b1, 1'b0);
        ui_in  = 8'hFF;
        uio_in = 8'hFF;
        #2;
        ui_in  = 8'h80;
        #1;
        n_cmp++;
        if (uo_out !== 8'h0C) begin
            n_fail++;
            $display("FAIL between_edges: uo_out=%h required 0c", uo_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        logic en, rst;
        for (int i = 0; i < 300; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 19) == 0);
            drive(a, b, en, rst);
            n_cmp++;
            if (uo_out !== exp_q) begin
                n_fail++;
                $display("FAIL random%0d: a=%h b=%h ena=%b rst=%b uo_out=%h required %h",
                         i, a, b, en, rst, uo_out, exp_q);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        mon_on = 1'b1;
        test_reset();
        test_vectors();
        test_hold_then_reset();
        test_reset_priority();
        test_between_edges();
        test_back_to_back();
        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_tt_um_or_and_selector
